vec_mem_arbiter: RTL

Two-requester memory arbiter sharing one native-protocol memory port between the picorv32 core port and the picorv32_pcpi_vec coprocessor port. It sits between the two masters and the single SRAM/bus slave, so that scalar fetches/loads/stores and vector unit-stride/strided accesses (vle/vse/vlse/vsse) target one shared memory. Exactly one transaction is in flight at a time. Fairness is fixed-priority or round-robin, and a watchdog recovers from a silent slave.

---
 rtl/vec_mem_arb_pkg.sv | 11 +
 rtl/vec_mem_arb_pick.sv | 26 ++
 rtl/vec_mem_arbiter.sv | 119 +++++++++++
 3 files changed

// File: rtl/vec_mem_arb_pkg.sv
// vec_mem_arb_pkg: shared types and constants for the CPU/vector memory arbiter
//   state_e       : arbiter FSM states
//   OWN_*         : arb_owner encodings
//   TIMEOUT_RDATA : read data returned to the owner on a watchdog expiry
package vec_mem_arb_pkg;
   typedef enum logic [1:0] {IDLE, BUSY_CPU, BUSY_VEC} state_e;
   localparam logic [1:0]  OWN_NONE      = 2'b00;
   localparam logic [1:0]  OWN_CPU       = 2'b01;
   localparam logic [1:0]  OWN_VEC       = 2'b10;
   localparam logic [31:0] TIMEOUT_RDATA = 32'h0;
endpackage

// File: rtl/vec_mem_arb_pick.sv
// vec_mem_arb_pick: combinational grant select between the CPU and vector ports
//   cpu_req_i / vec_req_i : pending requests
//   last_vec_i            : 1 when the vector port owned the last completed access
//   grant_cpu_o / grant_vec_o : one-hot (or zero) grant
//   VEC_MEM_ARB_RR_EN defined   : round-robin on a tie (grant the port that was not last)
//   VEC_MEM_ARB_RR_EN undefined : fixed priority, VEC_FIRST selects the winner
module vec_mem_arb_pick #(
   parameter bit VEC_FIRST = 1'b0
) (
   input  logic cpu_req_i,
   input  logic vec_req_i,
   input  logic last_vec_i,
   output logic grant_cpu_o,
   output logic grant_vec_o
);
   logic tie_vec;
`ifdef VEC_MEM_ARB_RR_EN
   assign tie_vec = ~last_vec_i;
`else
   logic unused_last;
   assign unused_last = last_vec_i;
   assign tie_vec     = VEC_FIRST;
`endif
   assign grant_vec_o = vec_req_i & (~cpu_req_i | tie_vec);
   assign grant_cpu_o = cpu_req_i & ~grant_vec_o;
endmodule

// File: rtl/vec_mem_arbiter.sv
// vec_mem_arbiter: shares one native memory port between the picorv32 core and the vector coprocessor
//   cpu_mem_* : CPU requester port (valid/instr/addr/wdata/wstrb in, ready/rdata out)
//   vec_mem_* : vector requester port (valid/addr/wdata/wstrb in, ready/rdata out)
//   mem_*     : downstream port (registered request, ready/rdata in)
//   arb_owner : 01 CPU, 10 vector, 00 idle; timeout_err: sticky watchdog flag
//   VEC_MEM_ARB_RR_EN selects round-robin instead of fixed priority (resolved in vec_mem_arb_pick)
import vec_mem_arb_pkg::*;
module vec_mem_arbiter #(
   parameter int TIMEOUT_CYCLES = 64,
   parameter bit VEC_FIRST      = 1'b0
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        cpu_mem_valid,
   input  logic        cpu_mem_instr,
   input  logic [31:0] cpu_mem_addr,
   input  logic [31:0] cpu_mem_wdata,
   input  logic [3:0]  cpu_mem_wstrb,
   output logic        cpu_mem_ready,
   output logic [31:0] cpu_mem_rdata,
   input  logic        vec_mem_valid,
   input  logic [31:0] vec_mem_addr,
   input  logic [31:0] vec_mem_wdata,
   input  logic [3:0]  vec_mem_wstrb,
   output logic        vec_mem_ready,
   output logic [31:0] vec_mem_rdata,
   output logic        mem_valid,
   output logic        mem_instr,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_wstrb,
   input  logic        mem_ready,
   input  logic [31:0] mem_rdata,
   output logic [1:0]  arb_owner,
   output logic        timeout_err
);
   // keep at least one bit so TIMEOUT_CYCLES=0 still elaborates
   localparam int WD_W = TIMEOUT_CYCLES > 0 ? $clog2(TIMEOUT_CYCLES + 1) : 1;

   state_e            state_q, state_d;
   logic              last_vec_q, mem_valid_q, mem_instr_q, timeout_err_q;
   logic [31:0]       mem_addr_q, mem_wdata_q, cpu_rdata_q, vec_rdata_q;
   logic [3:0]        mem_wstrb_q;
   logic [WD_W-1:0]   wd_cnt_q;
   logic              idle, busy, expire, done, grant_cpu, grant_vec;
   logic [31:0]       rdata_now;

   vec_mem_arb_pick #(.VEC_FIRST(VEC_FIRST)) u_pick (
      .cpu_req_i   (cpu_mem_valid),
      .vec_req_i   (vec_mem_valid),
      .last_vec_i  (last_vec_q),
      .grant_cpu_o (grant_cpu),
      .grant_vec_o (grant_vec)
   );

   assign idle      = state_q == IDLE;
   assign busy      = !idle;
   // mem_ready wins over a coincident expiry: the slave answered in time
   assign expire    = TIMEOUT_CYCLES != 0 && busy && !mem_ready && wd_cnt_q == WD_W'(TIMEOUT_CYCLES - 1);
   assign done      = busy && (mem_ready || expire);
   assign rdata_now = mem_ready ? mem_rdata : TIMEOUT_RDATA;

   assign cpu_mem_ready = done && state_q == BUSY_CPU;
   assign vec_mem_ready = done && state_q == BUSY_VEC;
   assign cpu_mem_rdata = cpu_mem_ready ? rdata_now : cpu_rdata_q;
   assign vec_mem_rdata = vec_mem_ready ? rdata_now : vec_rdata_q;
   assign arb_owner     = state_q == BUSY_CPU ? OWN_CPU : state_q == BUSY_VEC ? OWN_VEC : OWN_NONE;
   assign mem_valid     = mem_valid_q;
   assign mem_instr     = mem_instr_q;
   assign mem_addr      = mem_addr_q;
   assign mem_wdata     = mem_wdata_q;
   assign mem_wstrb     = mem_wstrb_q;
   assign timeout_err   = timeout_err_q;

   always_comb begin
      state_d = state_q;
      if (idle)
         state_d = grant_cpu ? BUSY_CPU : grant_vec ? BUSY_VEC : IDLE;
      else if (done)
         state_d = IDLE;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q       <= IDLE;
         last_vec_q    <= 1'b1;
         mem_valid_q   <= 1'b0;
         mem_instr_q   <= 1'b0;
         mem_addr_q    <= '0;
         mem_wdata_q   <= '0;
         mem_wstrb_q   <= '0;
         wd_cnt_q      <= '0;
         timeout_err_q <= 1'b0;
         cpu_rdata_q   <= '0;
         vec_rdata_q   <= '0;
      end else begin
         state_q <= state_d;
         if (idle && (grant_cpu || grant_vec)) begin
            mem_valid_q <= 1'b1;
            mem_instr_q <= grant_cpu & cpu_mem_instr;
            mem_addr_q  <= grant_cpu ? cpu_mem_addr : vec_mem_addr;
            mem_wdata_q <= grant_cpu ? cpu_mem_wdata : vec_mem_wdata;
            mem_wstrb_q <= grant_cpu ? cpu_mem_wstrb : vec_mem_wstrb;
            wd_cnt_q    <= '0;
         end else if (done) begin
            mem_valid_q <= 1'b0;
            last_vec_q  <= state_q == BUSY_VEC;
         end else if (busy && wd_cnt_q != {WD_W{1'b1}}) begin
            wd_cnt_q <= wd_cnt_q + WD_W'(1);
         end
         if (expire)
            timeout_err_q <= 1'b1;
         if (cpu_mem_ready)
            cpu_rdata_q <= cpu_mem_rdata;
         if (vec_mem_ready)
            vec_rdata_q <= vec_mem_rdata;
      end
   end
endmodule
